mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, legal range 1..15, giving the maximum accepted beats per grant before forced rotation.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 8 bits, level request per requester; bit i belongs to requester i.
REQ-005 The block SHALL have port in, input, 8 bits, 1-bit data per requester; bit i belongs to requester i.
REQ-006 The block SHALL have port out_ready, input, 1 bit, downstream accepts the current beat.
REQ-007 The block SHALL have port out, output, 1 bit, selected data: in[sel] while in GRANT, else 0.
REQ-008 The block SHALL have port out_valid, output, 1 bit, beat valid.
REQ-009 The block SHALL have port gnt, output, 8 bits, registered one-hot grant, all-zero when idle.
REQ-010 The block SHALL have port sel, output, 3 bits, registered binary index of the granted requester, driving the internal 8:1 select.
REQ-011 The block SHALL have port busy, output, 1 bit, high while in GRANT.

Function
REQ-012 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-013 The block SHALL keep a 3-bit priority pointer ptr; requester ptr has highest priority, then ptr+1, and so on mod 8.
REQ-014 IDLE with req != 0: on the next edge, the block SHALL pick the first set req bit searching from ptr upward with wrap (7 -> 0), load sel and gnt, clear beat count, and enter GRANT.
REQ-015 IDLE with req == 0: the block SHALL stay in IDLE, with gnt = 0 and sel holding its previous value.
REQ-016 Grant latency SHALL be exactly 1 cycle from req sampled in IDLE to gnt/busy high.
REQ-017 In GRANT, out_valid SHALL be req[sel], combinational; in IDLE, out_valid SHALL be 0.
REQ-018 In GRANT, out SHALL equal in[sel], combinational through the 8:1 mux; in IDLE, out SHALL be 0.
REQ-019 A beat SHALL occur when out_valid and out_ready are both high at a rising edge; each beat SHALL increment the 4-bit beat count.
REQ-020 The block SHALL release the grant (next state IDLE, gnt -> 0, ptr -> sel+1 mod 8) on the edge where req[sel] = 0, or on the edge of the beat that makes the count equal MAX_BURST.
REQ-021 If req[sel] = 0 and out_ready = 1 in the same cycle, no beat SHALL be counted and the grant SHALL release.
REQ-022 out_ready = 0 with req[sel] = 1 SHALL hold GRANT indefinitely, with the count unchanged and no timeout.
REQ-023 After any release, the block SHALL spend at least one IDLE cycle (bubble) before the next grant, including re-grant of the same requester.
REQ-024 Changes on req bits other than sel SHALL NOT affect an active grant.
REQ-025 gnt SHALL always equal one-hot(sel) in GRANT and 0 in IDLE; gnt SHALL never have more than one bit set.
REQ-026 With MAX_BURST = 1, every accepted beat SHALL release the grant.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, ptr = 0, sel = 0, gnt = 0, beat count = 0, busy = 0, out_valid = 0, out = 0, regardless of clk.
REQ-028 Reset asserted mid-grant SHALL abort the grant with no beat counted; after deassertion, arbitration SHALL restart from ptr = 0.
REQ-029 Reset deassertion SHALL take effect at the first rising edge of clk after rst_n goes high; no grant SHALL occur on that same edge.

Verification
REQ-030 Reset, then req = 8'h01, in = 8'h01, out_ready = 1 -> gnt = 8'h01, sel = 0 after 1 cycle; out = 1, out_valid = 1 for 4 beats; release; ptr = 1; re-grant to requester 0 after a 1-cycle IDLE bubble.
REQ-031 req = 8'hFF held, out_ready = 1, MAX_BURST = 4 -> grants rotate 0,1,...,7,0, each 4 beats followed by 1 IDLE cycle.
REQ-032 ptr = 6, req = 8'h21 -> grant to requester 0 (wrap past 7, not 5 first); after release, ptr = 1 and requester 5 wins next.
REQ-033 Grant to requester 3, out_ready = 0 for 10 cycles -> gnt = 8'h08 held, out_valid = 1, count = 0; then drop req[3] -> IDLE on the next edge, ptr = 4.
REQ-034 Grant to requester 2 after 2 beats, pulse rst_n low between edges -> gnt = 0, out_valid = 0 immediately; after release with req = 8'h84, requester 2 wins (ptr = 0).
REQ-035 The bench SHALL check continuously that gnt is one-hot-or-zero, gnt = one-hot(sel) when busy, and out = in[sel] whenever busy.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter in front of an 8:1 one-bit data mux. One requester
//   owns the output at a time; it keeps the grant until it drops its request
//   or until MAX_BURST beats have been accepted, after which priority rotates
//   to the requester just past it. Every release is followed by at least one
//   IDLE cycle before the next grant.
//
// Parameters
//   MAX_BURST  beats accepted per grant before forced rotation (1..15)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   level request per requester
//   in[7:0]    one data bit per requester
//   out_ready  downstream accepts the current beat
//   out        in[sel] while granted, else 0 (combinational)
//   out_valid  req[sel] while granted, else 0 (combinational)
//   gnt[7:0]   registered one-hot grant, zero when idle
//   sel[2:0]   registered index of the granted requester
//   busy       high while a grant is active
module mux_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] in,
    input  logic       out_ready,
    output logic       out,
    output logic       out_valid,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_d;
    logic [7:0] gnt_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic       run_q;
    logic [2:0] pick;
    logic [2:0] idx;
    logic       any_req;
    logic       granted;
    logic       sel_req;
    logic       sel_in;
    logic       beat;

    // run_q is cleared by reset and sets on the first edge after release,
    // so the edge on which reset deasserts never issues a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            sel     <= 3'd0;
            gnt     <= 8'd0;
            cnt_q   <= 4'd0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel     <= sel_d;
            gnt     <= gnt_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
        end
    end

    // Rotating priority search: walk offsets from 7 down to 0 so the
    // smallest offset from ptr that has a request is the one left in pick.
    always_comb begin
        pick = ptr_q;
        idx  = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr_q + 3'(k);
            if (req[idx]) pick = idx;
        end
    end

    assign any_req = |req;
    assign granted = (state_q == GRANT);
    assign sel_req = req[sel];
    assign sel_in  = in[sel];
    assign beat    = granted & sel_req & out_ready;
    assign cnt_inc = cnt_q + 4'd1;

    assign busy      = granted;
    assign out_valid = granted & sel_req;
    assign out       = granted & sel_in;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel;
        gnt_d   = gnt;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = 8'd0;
                if (run_q && any_req) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    gnt_d   = 8'd1 << pick;
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                // A dropped request wins over out_ready: no beat is counted.
                if (!sel_req) begin
                    state_d = IDLE;
                    gnt_d   = 8'd0;
                    ptr_d   = sel + 3'd1;
                    cnt_d   = 4'd0;
                end else if (beat) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == BURST_LIM) begin
                        state_d = IDLE;
                        gnt_d   = 8'd0;
                        ptr_d   = sel + 3'd1;
                        cnt_d   = 4'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic [7:0] in = 8'd0;
    logic       out_ready = 1'b0;
    logic       out, out_valid, busy;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       b_out, b_valid, b_busy;
    logic [7:0] b_gnt;
    logic [2:0] b_sel;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .in(in), .out_ready(out_ready),
        .out(out), .out_valid(out_valid), .gnt(gnt), .sel(sel), .busy(busy)
    );

    mux_rr_arbiter #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .in(in), .out_ready(out_ready),
        .out(b_out), .out_valid(b_valid), .gnt(b_gnt), .sel(b_sel), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge: pulse reset between edges, then take the
    // release edge (which must not grant).
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    // Invariants sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
            if (busy) begin
                chk("gnt_vs_sel", 32'(gnt), 32'(8'd1 << sel));
                chk("out_vs_in", 32'(out), 32'(in[sel]));
            end else begin
                chk("gnt_idle", 32'(gnt), 32'd0);
            end
        end
    end

    initial begin
        // Reset state with everything requesting and all data high.
        req = 8'hFF; in = 8'hFF; out_ready = 1'b1;
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);

        // Single requester, full burst, bubble, re-grant.
        req = 8'h01; in = 8'h01;
        rst_n = 1'b1;
        tick();
        chk("a_no_grant_on_release", 32'(busy), 32'd0);
        tick();
        chk("a_gnt", 32'(gnt), 32'h01);
        chk("a_sel", 32'(sel), 32'd0);
        chk("a_out", 32'(out), 32'd1);
        chk("a_valid", 32'(out_valid), 32'd1);
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("a_busy", 32'(busy), 32'(b < 3));
            if (b < 3) begin
                chk("a_out_b", 32'(out), 32'd1);
                chk("a_valid_b", 32'(out_valid), 32'd1);
            end
        end
        chk("a_rel_gnt", 32'(gnt), 32'd0);
        chk("a_ptr", 32'(dut.ptr_q), 32'd1);
        tick();
        chk("a_regrant_busy", 32'(busy), 32'd1);
        chk("a_regrant_sel", 32'(sel), 32'd0);

        // All requesting: rotation 0..7,0 with 4 beats and one bubble each.
        #1;
        req = 8'hFF; in = 8'hA5;
        do_reset();
        for (int g = 0; g < 9; g++) begin
            tick();
            chk("b_busy", 32'(busy), 32'd1);
            chk("b_sel", 32'(sel), 32'(g % 8));
            for (int b = 0; b < 4; b++) begin
                tick();
                chk("b_burst", 32'(busy), 32'(b < 3));
            end
        end

        // Wrap past 7: get ptr to 6, then req 0x21 picks 0, then 5.
        req = 8'h20;
        do_reset();
        tick();
        chk("c_sel5", 32'(sel), 32'd5);
        req = 8'h00;
        tick();
        chk("c_ptr6", 32'(dut.ptr_q), 32'd6);
        req = 8'h21;
        tick();
        chk("c_wrap_sel", 32'(sel), 32'd0);
        req = 8'h20;
        tick();
        chk("c_rel", 32'(busy), 32'd0);
        chk("c_ptr1", 32'(dut.ptr_q), 32'd1);
        tick();
        chk("c_next_sel", 32'(sel), 32'd5);

        // Stall: out_ready low holds the grant with no beats counted.
        req = 8'h08; out_ready = 1'b0;
        do_reset();
        tick();
        chk("d_gnt", 32'(gnt), 32'h08);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("d_hold_gnt", 32'(gnt), 32'h08);
            chk("d_hold_valid", 32'(out_valid), 32'd1);
            chk("d_hold_cnt", 32'(dut.cnt_q), 32'd0);
        end
        req = 8'h00; out_ready = 1'b1;
        tick();
        chk("d_rel", 32'(busy), 32'd0);
        chk("d_ptr4", 32'(dut.ptr_q), 32'd4);
        req = 8'h18;
        tick();
        chk("d_next_sel", 32'(sel), 32'd4);

        // Reset mid-grant after 2 beats; other req bits do not disturb it.
        req = 8'h04; in = 8'h04;
        do_reset();
        tick();
        chk("e_sel", 32'(sel), 32'd2);
        req = 8'hFF;
        tick();
        tick();
        chk("e_cnt2", 32'(dut.cnt_q), 32'd2);
        chk("e_hold_sel", 32'(sel), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("e_rst_gnt", 32'(gnt), 32'd0);
        chk("e_rst_valid", 32'(out_valid), 32'd0);
        chk("e_rst_out", 32'(out), 32'd0);
        chk("e_rst_busy", 32'(busy), 32'd0);
        req = 8'h84;
        #1;
        rst_n = 1'b1;
        tick();
        chk("e_no_grant_on_release", 32'(busy), 32'd0);
        tick();
        chk("e_sel_after", 32'(sel), 32'd2);

        // MAX_BURST = 1: every beat releases, one bubble between grants.
        req = 8'hFF; out_ready = 1'b1;
        do_reset();
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("f_busy", 32'(b_busy), 32'd1);
            chk("f_sel", 32'(b_sel), 32'(g));
            tick();
            chk("f_rel", 32'(b_busy), 32'd0);
        end

        // Dropped request with out_ready high: release with no beat counted.
        req = 8'h02;
        do_reset();
        tick();
        chk("g_sel", 32'(sel), 32'd1);
        req = 8'h00;
        #1;
        chk("g_valid_low", 32'(out_valid), 32'd0);
        tick();
        chk("g_rel", 32'(busy), 32'd0);
        chk("g_ptr2", 32'(dut.ptr_q), 32'd2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
